// File: rtl/spio_spinnaker_link_tx_2of7.sv
// SpiNNaker link transmitter: serialises 40/72-bit packets as 2-of-7 NRZ
// symbols, one outstanding symbol at a time, paced by a resynchronised ack.
module spio_spinnaker_link_tx_2of7 #(
  parameter int unsigned ACK_SYNC_STAGES = 2
) (
  input  logic        CLK_IN,
  input  logic        RESET_IN,
  input  logic [71:0] PKT_DATA_IN,
  input  logic        PKT_VLD_IN,
  output logic        PKT_RDY_OUT,
  output logic [6:0]  SL_OUT_DATA,
  input  logic        SL_OUT_ACK
);

  localparam int unsigned CW       = $clog2(ACK_SYNC_STAGES + 1);
  localparam logic [6:0]  EOP_CODE = 7'h50;

  typedef enum logic [2:0] {
    FLUSH_WAIT,
    FLUSH,
    FLUSH_ACK,
    IDLE,
    SEND,
    WAIT_ACK,
    SEND_EOP,
    WAIT_EOP
  } state_t;

  state_t                     state_q, state_d;
  logic [ACK_SYNC_STAGES-1:0] sync_q, sync_d;
  logic                       ack_ref_q, ack_ref_d;
  logic [CW-1:0]              fw_cnt_q, fw_cnt_d;
  logic [71:0]                pkt_q, pkt_d;
  logic [4:0]                 idx_q, idx_d;
  logic [4:0]                 cnt_q, cnt_d;
  logic [6:0]                 data_q, data_d;
  logic                       rdy_q, rdy_d;
  logic                       ack_s;
  logic                       ack_evt;
  logic [4:0]                 idx_inc;

  function automatic logic [6:0] nib_code(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0:    code = 7'h11;
      4'h1:    code = 7'h12;
      4'h2:    code = 7'h14;
      4'h3:    code = 7'h18;
      4'h4:    code = 7'h21;
      4'h5:    code = 7'h22;
      4'h6:    code = 7'h24;
      4'h7:    code = 7'h28;
      4'h8:    code = 7'h41;
      4'h9:    code = 7'h42;
      4'hA:    code = 7'h44;
      4'hB:    code = 7'h48;
      4'hC:    code = 7'h03;
      4'hD:    code = 7'h0C;
      4'hE:    code = 7'h30;
      default: code = 7'h60;
    endcase
    return code;
  endfunction

  assign ack_s       = sync_q[ACK_SYNC_STAGES-1];
  assign ack_evt     = (ack_s != ack_ref_q);
  assign idx_inc     = idx_q + 5'd1;
  assign PKT_RDY_OUT = rdy_q;
  assign SL_OUT_DATA = data_q;

  always_comb begin
    state_d   = state_q;
    sync_d    = {sync_q[ACK_SYNC_STAGES-2:0], SL_OUT_ACK};
    ack_ref_d = ack_evt ? ack_s : ack_ref_q;
    fw_cnt_d  = fw_cnt_q;
    pkt_d     = pkt_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    rdy_d     = rdy_q;

    unique case (state_q)
      FLUSH_WAIT: begin
        if (fw_cnt_q == CW'(ACK_SYNC_STAGES - 1)) begin
          ack_ref_d = ack_s;
          state_d   = FLUSH;
        end else begin
          fw_cnt_d = fw_cnt_q + 1'b1;
        end
      end
      FLUSH: begin
        data_d  = data_q ^ EOP_CODE;
        state_d = FLUSH_ACK;
      end
      FLUSH_ACK: begin
        if (ack_evt) begin
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (rdy_q && PKT_VLD_IN) begin
          pkt_d   = PKT_DATA_IN;
          cnt_d   = PKT_DATA_IN[1] ? 5'd18 : 5'd10;
          idx_d   = '0;
          rdy_d   = 1'b0;
          state_d = SEND;
        end
      end
      SEND: begin
        data_d  = data_q ^ nib_code(pkt_q[3:0]);
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        // The packet register shifts down so the current nibble is always at [3:0].
        if (ack_evt) begin
          idx_d   = idx_inc;
          pkt_d   = pkt_q >> 4;
          state_d = (idx_inc == cnt_q) ? SEND_EOP : SEND;
        end
      end
      SEND_EOP: begin
        data_d  = data_q ^ EOP_CODE;
        state_d = WAIT_EOP;
      end
      WAIT_EOP: begin
        if (ack_evt) begin
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = FLUSH_WAIT;
    endcase
  end

  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      state_q   <= FLUSH_WAIT;
      sync_q    <= '0;
      ack_ref_q <= 1'b0;
      fw_cnt_q  <= '0;
      pkt_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      ack_ref_q <= ack_ref_d;
      fw_cnt_q  <= fw_cnt_d;
      pkt_q     <= pkt_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      rdy_q     <= rdy_d;
    end
  end

endmodule

// File: tb/tb_spio_spinnaker_link_tx_2of7.sv
// Bench for the 2-of-7 link transmitter: a far-end responder echoes acks and
// records every symbol, which is compared with a packet-level symbol model.
module tb_spio_spinnaker_link_tx_2of7;

  localparam int unsigned STAGES = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [71:0] din;
  logic        vld;
  logic        rdy;
  logic [6:0]  sl_data;
  logic        ack;

  always #5 clk = ~clk;

  spio_spinnaker_link_tx_2of7 #(.ACK_SYNC_STAGES(STAGES)) u_dut (
    .CLK_IN      (clk),
    .RESET_IN    (rst),
    .PKT_DATA_IN (din),
    .PKT_VLD_IN  (vld),
    .PKT_RDY_OUT (rdy),
    .SL_OUT_DATA (sl_data),
    .SL_OUT_ACK  (ack)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Far-end responder: records each symbol's toggle mask and toggles ack
  // ack_delay cycles after each symbol while ack_en is set.
  logic [6:0]  masks[$];
  logic [6:0]  prev;
  bit          ack_en = 1'b1;
  int unsigned ack_delay = 5;
  int unsigned ack_cnt = 0;
  int unsigned man_req = 0;
  int unsigned man_done = 0;
  int unsigned cyc = 0;
  int unsigned last_tog_cyc = 0;
  int unsigned last_chg_cyc = 0;

  initial ack = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev    = sl_data;
      ack_cnt = 0;
    end else begin
      if (man_req != man_done) begin
        man_done     = man_req;
        ack          = ~ack;
        last_tog_cyc = cyc;
      end
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) begin
          ack          = ~ack;
          last_tog_cyc = cyc;
        end
      end
      if (sl_data !== prev) begin
        masks.push_back(sl_data ^ prev);
        last_chg_cyc = cyc;
        prev         = sl_data;
        if (ack_en) ack_cnt = ack_delay;
      end
    end
  end

  // Reference model: the symbol stream a packet must produce.
  logic [6:0] codes [16] = '{7'h11, 7'h12, 7'h14, 7'h18, 7'h21, 7'h22, 7'h24, 7'h28,
                             7'h41, 7'h42, 7'h44, 7'h48, 7'h03, 7'h0C, 7'h30, 7'h60};
  logic [6:0] exp_q[$];

  task automatic model_pkt(input logic [71:0] p);
    logic [71:0] t;
    int unsigned n;
    exp_q.delete();
    n = p[1] ? 18 : 10;
    for (int unsigned i = 0; i < n; i++) begin
      t = p >> (4 * i);
      exp_q.push_back(codes[t[3:0]]);
    end
    exp_q.push_back(7'h50);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rand_din();
    din = {8'($urandom), $urandom, $urandom};
  endtask

  task automatic wait_rdy(input int unsigned max, input string tag);
    for (int unsigned i = 0; i < max; i++) begin
      if (rdy === 1'b1) break;
      rand_din();
      step();
    end
    chk({tag, "_rdy_timeout"}, rdy, 1'b1);
  endtask

  task automatic wait_syms(input int unsigned n, input int unsigned max, input string tag);
    for (int unsigned i = 0; i < max; i++) begin
      if (masks.size() >= n) break;
      step();
    end
    chk({tag, "_sym_timeout"}, masks.size() >= n, 1'b1);
  endtask

  task automatic cmp_masks(input int unsigned base, input string tag);
    int unsigned got_n;
    got_n = masks.size() - base;
    chk({tag, "_nsym"}, got_n, exp_q.size());
    for (int unsigned i = 0; i < exp_q.size() && i < got_n; i++)
      chk($sformatf("%s_sym%0d", tag, i), masks[base + i], exp_q[i]);
  endtask

  task automatic do_reset(input string tag);
    int unsigned base;
    rst = 1'b1;
    vld = 1'b0;
    step();
    chk({tag, "_rst_data"}, sl_data, 7'h00);
    chk({tag, "_rst_rdy"}, rdy, 1'b0);
    step();
    rst  = 1'b0;
    base = masks.size();
    exp_q.delete();
    exp_q.push_back(7'h50);
    wait_rdy(200, tag);
    repeat (10) step();
    cmp_masks(base, {tag, "_flush"});
    chk({tag, "_idle_rdy"}, rdy, 1'b1);
  endtask

  task automatic accept(input logic [71:0] p, input string tag, output int unsigned base);
    logic [6:0] d0;
    wait_rdy(200, tag);
    model_pkt(p);
    base = masks.size();
    d0   = sl_data;
    din  = p;
    vld  = 1'b1;
    step();
    vld = 1'b0;
    rand_din();
    chk({tag, "_busy_rdy"}, rdy, 1'b0);
    step();
    chk({tag, "_first_sym"}, sl_data, d0 ^ exp_q[0]);
  endtask

  task automatic finish_pkt(input int unsigned base, input string tag);
    wait_rdy(5000, tag);
    chk({tag, "_rdy_after_eop_ack"}, last_tog_cyc > last_chg_cyc, 1'b1);
    cmp_masks(base, tag);
  endtask

  task automatic send_pkt(input logic [71:0] p, input string tag);
    int unsigned base;
    accept(p, tag, base);
    finish_pkt(base, tag);
  endtask

  initial begin
    int unsigned base;
    logic [71:0] p;
    logic [6:0]  hold;
    bit          stable;

    rst = 1'b1;
    vld = 1'b0;
    din = '0;
    step();

    do_reset("reset");

    send_pkt(72'h00_0000_0012_3456_7800, "pkt40");
    send_pkt(72'hFF_FFFF_FFFF_FFFF_FFFE, "pkt72");

    for (int unsigned k = 0; k < 8; k++) begin
      ack_delay = $urandom_range(1, 8);
      p = {8'($urandom), $urandom, $urandom};
      send_pkt(p, $sformatf("rnd%0d", k));
    end
    ack_delay = 5;

    // Ack withheld mid-packet, then released by hand.
    ack_en = 1'b0;
    accept({8'($urandom), $urandom, $urandom}, "hold", base);
    wait_syms(base + 1, 20, "hold");
    repeat (STAGES + 4) step();
    hold   = sl_data;
    stable = 1'b1;
    repeat (1000) begin
      rand_din();
      step();
      if (sl_data !== hold || rdy !== 1'b0) stable = 1'b0;
    end
    chk("hold_stable", stable, 1'b1);
    chk("hold_nsym", masks.size() - base, 1);
    ack_en = 1'b1;
    man_req++;
    wait_syms(base + 2, 50, "hold_release");
    chk("hold_latency", last_chg_cyc - last_tog_cyc, STAGES + 2);
    finish_pkt(base, "hold");

    // Spurious acks while idle must not produce symbols.
    base = masks.size();
    for (int unsigned k = 0; k < 3; k++) begin
      man_req++;
      repeat (7) step();
    end
    repeat (10) step();
    chk("spur_nsym", masks.size() - base, 0);
    chk("spur_rdy", rdy, 1'b1);
    send_pkt({8'($urandom), $urandom, $urandom}, "spur_pkt");

    // Reset in the middle of a packet: flush again, no resumption.
    accept(72'hFF_FFFF_FFFF_FFFF_FFFE, "midrst", base);
    wait_syms(base + 3, 200, "midrst");
    do_reset("midrst");

    send_pkt(72'h00_0000_00AB_CDEF_0120, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
